ibindct_8pt: RTL and testbench
==============================

# ibindct_8pt

Inverse 8-point 1-D binDCT for the image-decode path. It accepts one block of eight signed forward-binDCT coefficients and reconstructs eight signed samples. Every butterfly and shift-add lifting step of the forward transform is undone in reverse order. It sits after dequantisation, and is used twice per 8x8 block (rows, then columns) alongside the forward transform.

## Interface
- `IN_WIDTH`, default 30: coefficient width, matching the forward transform's full-precision output.
- `OUT_WIDTH`, default 20: reconstructed sample width (Y/Cb/Cr).
- `INTER_WIDTH`, default `IN_WIDTH+2`: internal register width.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `y_in[7:0]`, input, signed `IN_WIDTH` each: coefficients in natural order. `y_in[0]` is DC and `y_in[k]` is frequency k.
- `valid_in`, input, 1: `y_in` is valid.
- `in_ready`, output, 1: the block can accept a new vector this cycle.
- `x_out[7:0]`, output, signed `OUT_WIDTH` each: reconstructed samples.
- `valid_out`, output, 1: one-cycle pulse; `x_out` holds a new result.

## Operation
- State machine `state_t` has five states: IDLE, UNLIFT_D, BFLY_C, UNLIFT_B, BFLY_A.
  - IDLE → UNLIFT_D on `valid_in`.
  - UNLIFT_D → BFLY_C → UNLIFT_B → BFLY_A → IDLE, unconditionally.
- `in_ready = (state == IDLE)`.
- Handshake:
  - A vector is accepted on the edge where `valid_in && in_ready`; it is captured into `y_reg`, sign-extended to `INTER_WIDTH`.
  - `valid_in` while busy is ignored; nothing is captured and nothing is queued.
- All `>>>` are arithmetic shifts on `INTER_WIDTH` signed values. Every lifting step is the exact inverse of the forward step, so reconstruction is bit-exact.
- UNLIFT_D (result registered into `c_reg`):
  - `c7=y1`
  - `c4=y7+(c7>>>3)`
  - `c6=y3+(y5>>>1)`
  - `c5=y5-((c6>>>1)+(c6>>>2)+(c6>>>3))`
  - `c3=y2-((y6>>>2)+(y6>>>3))`
  - `c2=y6+((c3>>>2)+(c3>>>3))`
  - `c1=(y0>>>1)-y4`
  - `c0=y0-c1`
- BFLY_C (result into `a_reg`, `b_reg`):
  - `a0=(c0+c3)>>>1`, `a3=(c0-c3)>>>1`
  - `a1=(c1+c2)>>>1`, `a2=(c1-c2)>>>1`
  - `a4=(c4+c5)>>>1`, `b1=(c4-c5)>>>1`
  - `a7=(c7+c6)>>>1`, `b0=(c7-c6)>>>1`
- UNLIFT_B (updates `a5`, `a6` only):
  - `a5=(b0>>>1)+(b0>>>3)-b1`
  - `a6=b0-((a5>>>2)+(a5>>>3))`
- BFLY_A:
  - `x0=(a0+a7)>>>1`, `x7=(a0-a7)>>>1`
  - `x1=(a1+a6)>>>1`, `x6=(a1-a6)>>>1`
  - `x2=(a2+a5)>>>1`, `x5=(a2-a5)>>>1`
  - `x3=(a3+a4)>>>1`, `x4=(a3-a4)>>>1`
  - Each `x` is saturated to the signed `OUT_WIDTH` range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], then registered into `x_out`.
- `x_out` holds its value until the next BFLY_A edge.

## Timing
- Reset values:
  - `state=IDLE`.
  - All pipeline registers and `x_out` are 0.
  - `valid_out=0`, `in_ready=1`.
- Reset mid-operation aborts the block in flight: no `valid_out` pulse, and `x_out` is cleared to 0.
- Latency: for an acceptance edge at cycle N, `valid_out` is high during cycle N+5 only.
- Throughput: one vector per 5 cycles. `in_ready` is high during the `valid_out` cycle, so back-to-back blocks are accepted with no bubble beyond the 5-cycle cadence.
- `valid_out` is registered; `in_ready` is combinational from `state` only.

## Structure
- Shared package `bindct_pkg` holds:
  - `state_t`;
  - shift-add functions `mul_1_8`, `mul_3_8`, `mul_5_8`, `mul_7_8`, `half`, parameterised by width and reused by the forward transform;
  - default width constants.
- One sub-module is natural: `bindct_sat`, a signed saturating narrow from `INTER_WIDTH` to `OUT_WIDTH`, instantiated eight times.

## Test plan
- DC: `y=[800,0,0,0,0,0,0,0]` → `x_out` all 100; `valid_out` 5 cycles after acceptance.
- Impulse: `y=[64,64,55,36,32,56,-24,-8]` → `x_out=[64,0,0,0,0,0,0,0]`.
- Saturation: `y=[4194304,0,…,0]` → all `x_out=524287`.
- Round trip: 1000 random 20-bit vectors (include ±2^19 extremes) through the forward golden model at full precision, then into the DUT → exact match, no saturation.
- Busy/back-to-back:
  - hold `valid_in` high across 3 vectors → accepted every 5 cycles;
  - vectors presented while `in_ready=0` are dropped;
  - `valid_out` pulses exactly 3 times.
- Reset at cycle N+3 → no `valid_out`; `x_out=0`, `in_ready=1` next cycle; the next vector decodes correctly.

Source files
------------

// File: rtl/bindct_pkg.sv
// Shared binDCT definitions: FSM states, shift-add constant multipliers and default widths.
// Multipliers work on a 64-bit signed carrier; callers narrow the result back to their own width.
package bindct_pkg;

    localparam int DEF_IN_WIDTH  = 30;
    localparam int DEF_OUT_WIDTH = 20;
    localparam int MAXW          = 64;

    typedef logic signed [MAXW-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE,
        UNLIFT_D,
        BFLY_C,
        UNLIFT_B,
        BFLY_A
    } state_t;

    function automatic wide_t half(input wide_t v);
        return v >>> 1;
    endfunction

    function automatic wide_t mul_1_8(input wide_t v);
        return v >>> 3;
    endfunction

    function automatic wide_t mul_3_8(input wide_t v);
        return (v >>> 2) + (v >>> 3);
    endfunction

    function automatic wide_t mul_5_8(input wide_t v);
        return (v >>> 1) + (v >>> 3);
    endfunction

    function automatic wide_t mul_7_8(input wide_t v);
        return (v >>> 1) + (v >>> 2) + (v >>> 3);
    endfunction

endpackage

// File: rtl/bindct_sat.sv
// Signed saturating narrow from IW to OW bits; purely combinational, no backpressure.
module bindct_sat
    import bindct_pkg::*;
#(
    parameter int IW = DEF_IN_WIDTH + 2,
    parameter int OW = DEF_OUT_WIDTH
) (
    input  logic signed [IW-1:0] i_dat,
    output logic signed [OW-1:0] o_dat
);

    localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        o_dat = i_dat[OW-1:0];
        if (i_dat > MAX_V)
            o_dat = {1'b0, {(OW-1){1'b1}}};
        else if (i_dat < MIN_V)
            o_dat = {1'b1, {(OW-1){1'b0}}};
    end

endmodule

// File: rtl/ibindct_8pt.sv
// Inverse 8-point binDCT: eight coefficients in, eight saturated samples out, latency 5 cycles.
// One block per 5 cycles; valid_in while busy is ignored, nothing is queued.
module ibindct_8pt
    import bindct_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int INTER_WIDTH = IN_WIDTH + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  y_in [7:0],
    input  logic                        valid_in,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] x_out [7:0],
    output logic                        valid_out
);

    typedef logic signed [INTER_WIDTH-1:0] iw_t;

    function automatic iw_t trunc(input wide_t v);
        return v[INTER_WIDTH-1:0];
    endfunction

    function automatic iw_t hlf(input iw_t v);
        return trunc(half(wide_t'(v)));
    endfunction

    function automatic iw_t m18(input iw_t v);
        return trunc(mul_1_8(wide_t'(v)));
    endfunction

    function automatic iw_t m38(input iw_t v);
        return trunc(mul_3_8(wide_t'(v)));
    endfunction

    function automatic iw_t m58(input iw_t v);
        return trunc(mul_5_8(wide_t'(v)));
    endfunction

    function automatic iw_t m78(input iw_t v);
        return trunc(mul_7_8(wide_t'(v)));
    endfunction

    // Butterfly sums wrap at INTER_WIDTH before the halving shift.
    function automatic iw_t hsum(input iw_t p, input iw_t q);
        iw_t s;
        s = p + q;
        return hlf(s);
    endfunction

    function automatic iw_t hdif(input iw_t p, input iw_t q);
        iw_t s;
        s = p - q;
        return hlf(s);
    endfunction

    state_t r_state, w_state_nxt;
    iw_t    r_y [8], r_c [8], r_a [8], r_b [2];
    iw_t    w_c [8], w_a [8], w_b [2], w_x [8];
    iw_t    w_a5, w_a6;
    logic signed [OUT_WIDTH-1:0] w_xs [7:0], r_x [7:0];
    logic   r_vld;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (valid_in) w_state_nxt = UNLIFT_D;
            UNLIFT_D: w_state_nxt = BFLY_C;
            BFLY_C:   w_state_nxt = UNLIFT_B;
            UNLIFT_B: w_state_nxt = BFLY_A;
            BFLY_A:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin : p_unlift_d
        iw_t t7, t6, t3, t1;
        t7 = r_y[1];
        t6 = r_y[3] + hlf(r_y[5]);
        t3 = r_y[2] - m38(r_y[6]);
        t1 = hlf(r_y[0]) - r_y[4];
        w_c[7] = t7;
        w_c[6] = t6;
        w_c[5] = r_y[5] - m78(t6);
        w_c[4] = r_y[7] + m18(t7);
        w_c[3] = t3;
        w_c[2] = r_y[6] + m38(t3);
        w_c[1] = t1;
        w_c[0] = r_y[0] - t1;
    end

    // a5/a6 are produced by the following lifting stage, so they hold here.
    always_comb begin
        w_a[0] = hsum(r_c[0], r_c[3]);
        w_a[3] = hdif(r_c[0], r_c[3]);
        w_a[1] = hsum(r_c[1], r_c[2]);
        w_a[2] = hdif(r_c[1], r_c[2]);
        w_a[4] = hsum(r_c[4], r_c[5]);
        w_b[1] = hdif(r_c[4], r_c[5]);
        w_a[7] = hsum(r_c[7], r_c[6]);
        w_b[0] = hdif(r_c[7], r_c[6]);
        w_a[5] = r_a[5];
        w_a[6] = r_a[6];
    end

    assign w_a5 = m58(r_b[0]) - r_b[1];
    assign w_a6 = r_b[0] - m38(w_a5);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_x[k]   = hsum(r_a[k], r_a[7-k]);
            w_x[7-k] = hdif(r_a[k], r_a[7-k]);
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_sat
        bindct_sat #(.IW(INTER_WIDTH), .OW(OUT_WIDTH)) u_sat (
            .i_dat(w_x[g]),
            .o_dat(w_xs[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_y[i] <= '0;
                r_c[i] <= '0;
                r_a[i] <= '0;
                r_x[i] <= '0;
            end
            r_b[0] <= '0;
            r_b[1] <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in)
                        for (int i = 0; i < 8; i++) r_y[i] <= iw_t'(y_in[i]);
                end
                UNLIFT_D: r_c <= w_c;
                BFLY_C: begin
                    r_a <= w_a;
                    r_b <= w_b;
                end
                UNLIFT_B: begin
                    r_a[5] <= w_a5;
                    r_a[6] <= w_a6;
                end
                BFLY_A: begin
                    r_x   <= w_xs;
                    r_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign x_out     = r_x;
    assign valid_out = r_vld;

endmodule

// File: tb/tb_ibindct_8pt.sv
// Directed and round-trip bench for ibindct_8pt; expected values are hand-computed or
// come from an independent forward-binDCT model.
module tb_ibindct_8pt;

    localparam int NV = 6;

    typedef struct packed {
        logic [7:0][31:0] y;
        logic [7:0][31:0] x;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [29:0] y_in [7:0];
    logic               valid_in = 1'b0;
    logic               in_ready;
    logic signed [19:0] x_out [7:0];
    logic               valid_out;

    vec_t   tbl [NV];
    longint drv_y [8];
    longint exp_x [8];
    longint fx [8];
    int     n_tests = 0;
    int     n_fail  = 0;

    always #5 clk = ~clk;

    ibindct_8pt dut (
        .clk(clk),
        .rst(rst),
        .y_in(y_in),
        .valid_in(valid_in),
        .in_ready(in_ready),
        .x_out(x_out),
        .valid_out(valid_out)
    );

    function automatic vec_t mk(input int yy [8], input int xx [8]);
        vec_t r;
        for (int k = 0; k < 8; k++) begin
            r.y[k] = yy[k];
            r.x[k] = xx[k];
        end
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_x(input string nm);
        int bad;
        bad = -1;
        n_tests++;
        for (int k = 7; k >= 0; k--)
            if (longint'(x_out[k]) != exp_x[k]) bad = k;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: x_out[%0d]=%0d, expected %0d", nm, bad, x_out[bad], exp_x[bad]);
        end
    endtask

    task automatic load(input int idx);
        for (int k = 0; k < 8; k++) begin
            drv_y[k] = longint'($signed(tbl[idx].y[k]));
            exp_x[k] = longint'($signed(tbl[idx].x[k]));
        end
    endtask

    task automatic drive_vec();
        for (int k = 0; k < 8; k++) y_in[k] = drv_y[k][29:0];
    endtask

    // Presents drv_y for one cycle and returns the cycle count until valid_out (-1 on timeout).
    task automatic apply(output int lat);
        @(negedge clk);
        drive_vec();
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_out) lat = -1;
    endtask

    // Forward binDCT: the exact inverse of every step the DUT undoes.
    task automatic fwd_model();
        longint a [8];
        longint c [8];
        longint y [8];
        longint b0, b1;
        a[0] = fx[0] + fx[7];  a[7] = fx[0] - fx[7];
        a[1] = fx[1] + fx[6];  a[6] = fx[1] - fx[6];
        a[2] = fx[2] + fx[5];  a[5] = fx[2] - fx[5];
        a[3] = fx[3] + fx[4];  a[4] = fx[3] - fx[4];
        b0 = a[6] + ((a[5] >>> 2) + (a[5] >>> 3));
        b1 = (b0 >>> 1) + (b0 >>> 3) - a[5];
        c[0] = a[0] + a[3];  c[3] = a[0] - a[3];
        c[1] = a[1] + a[2];  c[2] = a[1] - a[2];
        c[4] = a[4] + b1;    c[5] = a[4] - b1;
        c[7] = a[7] + b0;    c[6] = a[7] - b0;
        y[1] = c[7];
        y[7] = c[4] - (c[7] >>> 3);
        y[5] = c[5] + ((c[6] >>> 1) + (c[6] >>> 2) + (c[6] >>> 3));
        y[3] = c[6] - (y[5] >>> 1);
        y[6] = c[2] - ((c[3] >>> 2) + (c[3] >>> 3));
        y[2] = c[3] + ((y[6] >>> 2) + (y[6] >>> 3));
        y[0] = c[0] + c[1];
        y[4] = (y[0] >>> 1) - c[1];
        for (int k = 0; k < 8; k++) begin
            drv_y[k] = y[k];
            exp_x[k] = fx[k];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int yy [8];
        int xx [8];
        int lat, lat_err, pulses, ir_err, tm_err;
        int b2b_idx [3];

        for (int k = 0; k < 8; k++) y_in[k] = '0;

        yy = '{800, 0, 0, 0, 0, 0, 0, 0};
        xx = '{100, 100, 100, 100, 100, 100, 100, 100};
        tbl[0] = mk(yy, xx);
        yy = '{64, 64, 55, 36, 32, 56, -24, -8};
        xx = '{64, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = mk(yy, xx);
        yy = '{4194304, 0, 0, 0, 0, 0, 0, 0};
        xx = '{524287, 524287, 524287, 524287, 524287, 524287, 524287, 524287};
        tbl[2] = mk(yy, xx);
        yy = '{-8388608, 0, 0, 0, 0, 0, 0, 0};
        xx = '{-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288};
        tbl[3] = mk(yy, xx);
        yy = '{0, 8, 0, 0, 0, 0, 0, 0};
        xx = '{2, 2, 1, 0, 0, -1, -2, -2};
        tbl[4] = mk(yy, xx);
        yy = '{-800, 0, 0, 0, 0, 0, 0, 0};
        xx = '{-100, -100, -100, -100, -100, -100, -100, -100};
        tbl[5] = mk(yy, xx);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset valid_out", longint'(valid_out), 0);
        for (int k = 0; k < 8; k++) exp_x[k] = 0;
        check_x("reset x_out");

        for (int i = 0; i < NV; i++) begin
            load(i);
            apply(lat);
            check($sformatf("vec%0d latency", i), lat, 5);
            check_x($sformatf("vec%0d data", i));
        end

        repeat (3) @(negedge clk);
        check("pulse width valid_out", longint'(valid_out), 0);
        check_x("hold x_out");

        b2b_idx = '{0, 4, 1};
        pulses = 0;
        ir_err = 0;
        tm_err = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid_out) begin
                if (pulses < 3) begin
                    load(b2b_idx[pulses]);
                    check_x($sformatf("b2b out%0d", pulses));
                end
                pulses++;
                if (i != 5 * pulses) tm_err++;
            end
            if (i < 15 && in_ready != (i % 5 == 0)) ir_err++;
            if (i < 15) begin
                if (i % 5 == 0) load(b2b_idx[i / 5]);
                else            load(2);
                drive_vec();
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
        end
        check("b2b pulse count", pulses, 3);
        check("b2b in_ready pattern errors", ir_err, 0);
        check("b2b pulse timing errors", tm_err, 0);

        load(1);
        @(negedge clk);
        drive_vec();
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset in_ready", longint'(in_ready), 1);
        check("midreset valid_out", longint'(valid_out), 0);
        for (int k = 0; k < 8; k++) exp_x[k] = 0;
        check_x("midreset x_out");
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        check("midreset stray pulses", pulses, 0);
        load(4);
        apply(lat);
        check("post-reset latency", lat, 5);
        check_x("post-reset data");

        lat_err = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 8; k++) begin
                if (n == 0)
                    fx[k] = -524288;
                else if (n == 1)
                    fx[k] = 524287;
                else if (n == 2)
                    fx[k] = (k % 2 == 0) ? 524287 : -524288;
                else if ($urandom_range(7, 0) == 0)
                    fx[k] = ($urandom_range(1, 0) != 0) ? 524287 : -524288;
                else
                    fx[k] = longint'($urandom_range(1048575, 0)) - 524288;
            end
            fwd_model();
            apply(lat);
            if (lat != 5) lat_err++;
            check_x($sformatf("roundtrip%0d", n));
        end
        check("roundtrip latency errors", lat_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
